// File: rtl/fib_engine_if.sv
// rtl/fib_engine_if.sv - control/data bundle between a requester and fib_engine
interface fib_engine_if #(
    parameter int W  = 32,
    parameter int NW = 6
);
    logic          start;
    logic          abort;
    logic          mode;
    logic [NW-1:0] init_n;
    logic [W-1:0]  init_a;
    logic [W-1:0]  init_b;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          overflow;

    modport master (
        output start, abort, mode, init_n, init_a, init_b,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, abort, mode, init_n, init_a, init_b,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/fib_engine.sv
// rtl/fib_engine.sv - iterative generalised Fibonacci engine, one step per clock
module fib_engine #(
    parameter int W  = 32,
    parameter int NW = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    fib_engine_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [NW-1:0] n_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  result_q;
    logic          mode_q;
    logic          ovf_q;

    logic [W:0]    sum_full;
    logic [W-1:0]  sum_step;

    // Bit W of the widened sum is the carry; saturate mode clamps on it.
    assign sum_full = {1'b0, a_q} + {1'b0, b_q};
    assign sum_step = (mode_q && sum_full[W]) ? {W{1'b1}} : sum_full[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            n_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            mode_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        n_q    <= bus.init_n;
                        a_q    <= bus.init_a;
                        b_q    <= bus.init_b;
                        mode_q <= bus.mode;
                        ovf_q  <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Abort wins over both a step and completion.
                    if (bus.abort) begin
                        ovf_q <= 1'b0;
                        state <= IDLE;
                    end else if (n_q != '0) begin
                        a_q <= b_q;
                        b_q <= sum_step;
                        n_q <= n_q - NW'(1);
                        if (sum_full[W]) ovf_q <= 1'b1;
                    end else begin
                        result_q <= a_q;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_fib_engine.sv
// tb/tb_fib_engine.sv - self-checking bench for fib_engine at W=32 and W=8 in lockstep
module tb_fib_engine;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_r32;
    logic [7:0]  last_r8;

    always #5 clk = ~clk;

    fib_engine_if #(.W(32), .NW(6)) bus32 ();
    fib_engine_if #(.W(8),  .NW(6)) bus8 ();

    fib_engine #(.W(32), .NW(6)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
    fib_engine #(.W(8),  .NW(6)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

    typedef struct {
        int          n;
        logic [31:0] a;
        logic [31:0] b;
        bit          mode;
        logic [31:0] r32;
        bit          o32;
        logic [7:0]  r8;
        bit          o8;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input bit s);
        bus32.start = s;
        bus8.start  = s;
    endtask

    task automatic set_abort(input bit s);
        bus32.abort = s;
        bus8.abort  = s;
    endtask

    task automatic set_inputs(input int n, input logic [31:0] a, input logic [31:0] b, input bit m);
        bus32.init_n = 6'(n);
        bus8.init_n  = 6'(n);
        bus32.init_a = a;
        bus8.init_a  = a[7:0];
        bus32.init_b = b;
        bus8.init_b  = b[7:0];
        bus32.mode   = m;
        bus8.mode    = m;
    endtask

    // Recursive definition unrolled: fib(n,a,b) = fib(n-1, b, a+b), clamped or wrapped at w bits.
    function automatic void model(input int w, input int n, input logic [31:0] a0, input logic [31:0] b0,
                                  input bit m, output logic [31:0] r, output bit ovf);
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned a = a0 & mask;
        longint unsigned b = b0 & mask;
        longint unsigned s;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            s = a + b;
            if (s > mask) begin
                ovf = 1'b1;
                s   = m ? mask : (s & mask);
            end
            a = b;
            b = s;
        end
        r = a[31:0];
    endfunction

    task automatic run_check(input string name, input int n, input logic [31:0] a, input logic [31:0] b,
                             input bit m, input logic [31:0] e32, input bit o32, input logic [7:0] e8, input bit o8);
        int cyc = 0;
        int busy_cnt = 1;
        bit both_hi = 1'b0;
        set_inputs(n, a, b, m);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        chk({name, " busy@E0"}, {bus32.busy, bus8.busy}, 2'b11);
        chk({name, " done@E0"}, {bus32.done, bus8.done}, 2'b00);
        chk({name, " ovf@E0"}, {bus32.overflow, bus8.overflow}, 2'b00);
        set_inputs($urandom_range(0, 63), $urandom, $urandom, 1'($urandom));
        while (!bus32.done && cyc < 100) begin
            set_start(1'($urandom));
            tick();
            cyc++;
            if (bus32.busy && bus32.done) both_hi = 1'b1;
            if (bus32.busy) busy_cnt++;
        end
        set_start(1'b0);
        chk({name, " latency"}, 64'(cyc), 64'(n + 1));
        chk({name, " busy_cycles"}, 64'(busy_cnt), 64'(n + 1));
        chk({name, " busy_done_excl"}, 64'(both_hi), 64'd0);
        chk({name, " done8"}, 64'(bus8.done), 64'd1);
        chk({name, " result32"}, 64'(bus32.result), 64'(e32));
        chk({name, " ovf32"}, 64'(bus32.overflow), 64'(o32));
        chk({name, " result8"}, 64'(bus8.result), 64'(e8));
        chk({name, " ovf8"}, 64'(bus8.overflow), 64'(o8));
        last_r32 = e32;
        last_r8  = e8;
    endtask

    task automatic chk_outputs_zero(input string name);
        chk(name, {bus32.busy, bus32.done, bus32.overflow, bus32.result, bus8.busy, bus8.done, bus8.overflow, bus8.result}, 64'd0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] r32, ra, rb;
        logic [31:0] r8w;
        bit o32, o8, seen_done;
        int n;
        bit m;

        vecs.push_back('{10, 32'd0,          32'd1,          1'b0, 32'd55,         1'b0, 8'd55,  1'b0});
        vecs.push_back('{0,  32'd7,          32'd9,          1'b0, 32'd7,          1'b0, 8'd7,   1'b0});
        vecs.push_back('{14, 32'd0,          32'd1,          1'b0, 32'd377,        1'b0, 8'd121, 1'b1});
        vecs.push_back('{14, 32'd0,          32'd1,          1'b1, 32'd377,        1'b0, 8'd255, 1'b1});
        vecs.push_back('{1,  32'hFFFF_FFFF,  32'd1,          1'b0, 32'd1,          1'b1, 8'd1,   1'b1});
        vecs.push_back('{1,  32'hFFFF_FFFF,  32'd1,          1'b1, 32'd1,          1'b1, 8'd1,   1'b1});
        vecs.push_back('{2,  32'h8000_0000,  32'h8000_0000,  1'b1, 32'hFFFF_FFFF,  1'b1, 8'd0,   1'b0});
        vecs.push_back('{2,  32'h8000_0000,  32'h8000_0000,  1'b0, 32'd0,          1'b1, 8'd0,   1'b0});
        vecs.push_back('{1,  32'd5,          32'd6,          1'b0, 32'd6,          1'b0, 8'd6,   1'b0});
        vecs.push_back('{63, 32'd0,          32'd1,          1'b1, 32'hFFFF_FFFF,  1'b1, 8'hFF,  1'b1});

        rst_n = 1'b0;
        set_start(1'b0);
        set_abort(1'b0);
        set_inputs(0, 32'd0, 32'd0, 1'b0);
        #3;
        chk_outputs_zero("reset_async");
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk_outputs_zero("idle_after_reset");

        foreach (vecs[i]) begin
            run_check($sformatf("vec%0d", i), vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].mode,
                      vecs[i].r32, vecs[i].o32, vecs[i].r8, vecs[i].o8);
        end

        set_abort(1'b1);
        tick();
        tick();
        set_abort(1'b0);
        chk("abort_in_done", {bus32.done, bus32.busy, bus32.result}, {1'b1, 1'b0, last_r32});

        set_inputs(3, 32'd2, 32'd3, 1'b0);
        set_start(1'b1);
        tick();
        chk("b2b_restart", {bus32.done, bus32.busy, bus8.done, bus8.busy}, 4'b0101);
        tick();
        set_start(1'b0);
        repeat (3) tick();
        chk("b2b_done", {bus32.done, bus32.result, bus8.done, bus8.result}, {1'b1, 32'd8, 1'b1, 8'd8});
        last_r32 = 32'd8;
        last_r8  = 8'd8;

        set_inputs(20, 32'hFFFF_FFFF, 32'd1, 1'b0);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        repeat (5) tick();
        chk("abort_pre", {bus32.busy, bus32.overflow, bus8.busy, bus8.overflow}, 4'b1111);
        set_abort(1'b1);
        tick();
        set_abort(1'b0);
        chk("abort_busy_fall", {bus32.busy, bus32.done, bus8.busy, bus8.done}, 4'b0000);
        chk("abort_result_kept", {bus32.result, bus8.result}, {last_r32, last_r8});
        chk("abort_ovf_clear", {bus32.overflow, bus8.overflow}, 2'b00);
        repeat (3) tick();
        chk("abort_stays_idle", {bus32.busy, bus32.done}, 2'b00);
        run_check("after_abort", 4, 32'd1, 32'd1, 1'b0, 32'd5, 1'b0, 8'd5, 1'b0);

        set_inputs(0, 32'd11, 32'd12, 1'b0);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        set_abort(1'b1);
        tick();
        set_abort(1'b0);
        chk("abort_beats_done", {bus32.busy, bus32.done, bus32.result}, {2'b00, last_r32});

        set_inputs(20, 32'd0, 32'd1, 1'b0);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1 chk_outputs_zero("reset_mid_run");
        #1 rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus32.done || bus8.done || bus32.busy) seen_done = 1'b1;
        end
        chk("no_done_after_reset", 64'(seen_done), 64'd0);

        for (int k = 0; k < 30; k++) begin
            n  = ($urandom_range(0, 7) == 0) ? $urandom_range(21, 63) : $urandom_range(0, 20);
            ra = $urandom;
            rb = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 15));
            m  = 1'($urandom);
            model(32, n, ra, rb, m, r32, o32);
            model(8,  n, ra, rb, m, r8w, o8);
            run_check($sformatf("rnd%0d", k), n, ra, rb, m, r32, o32, r8w[7:0], o8);
            if ($urandom_range(0, 2) == 0) begin
                set_abort(1'($urandom));
                tick();
                set_abort(1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fib_engine.md
FIB_ENGINE -- requirements
Module: fib_engine

Interface
REQ-001 SHALL have parameter W, default 32: width of the a, b and result data paths (W >= 2).
REQ-002 SHALL have parameter NW, default 6: width of the iteration count (NW >= 1).
REQ-003 SHALL have port clk  input  1: single clock, all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous reset, active low.
REQ-005 SHALL have port start  input  1: request to begin a computation; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1: cancel the computation in progress; sampled only in RUN.
REQ-007 SHALL have port mode  input  1: arithmetic mode, 0 = wrap, 1 = saturate; captured with start.
REQ-008 SHALL have port init_n  input  NW: iteration count n.
REQ-009 SHALL have port init_a  input  W: initial a.
REQ-010 SHALL have port init_b  input  W: initial b.
REQ-011 SHALL have port busy  output  1: high while in RUN.
REQ-012 SHALL have port done  output  1: high while in DONE.
REQ-013 SHALL have port result  output  W: final a of the last completed computation.
REQ-014 SHALL have port overflow  output  1: at least one step of the last computation produced a carry out of W bits.

Function
REQ-015 SHALL compute fib(n,a,b): if n==0 return a, else fib(n-1, b, a+b).
REQ-016 SHALL implement states IDLE, RUN and DONE, with exactly one state active at a time.
REQ-017 IDLE with start=1 at edge E0 SHALL load n, a, b and mode from the inputs, clear overflow, and enter RUN.
REQ-018 IDLE with start=0 SHALL hold all registers.
REQ-019 RUN with abort=0 and n!=0 SHALL perform one step per edge: a<=b, b<=sum, n<=n-1.
REQ-020 RUN with abort=0 and n==0 SHALL set result<=a and enter DONE.
REQ-021 Timing: done SHALL rise at edge E0+n+1 (for n=0, at E0+1).
REQ-022 sum SHALL be a+b computed at W+1 bits; bit W is the carry.
REQ-023 In wrap mode, sum SHALL be truncated to the low W bits (result mod 2^W).
REQ-024 In saturate mode, a carry SHALL force sum to all ones.
REQ-025 Any step whose carry is 1 SHALL set overflow, in either mode; overflow stays set until the next accepted start.
REQ-026 RUN with abort=1 SHALL enter IDLE at that edge, with no step performed, result and done unchanged, and overflow cleared.
REQ-027 abort SHALL take priority over both step and completion in the same cycle.
REQ-028 DONE SHALL hold result and done=1 until an edge with start=1.
REQ-029 That edge SHALL behave as an IDLE start (REQ-017), so back-to-back computations are possible with no idle cycle; done falls at that edge.
REQ-030 start while in RUN SHALL be ignored, and abort outside RUN SHALL be ignored.
REQ-031 Input changes on init_* or mode after E0 SHALL NOT affect a computation in progress.
REQ-032 busy and done SHALL be registered (decoded from the state register) and never both high.
REQ-033 The n, a and b registers SHALL be exactly NW, W and W bits, with no truncation of inputs.

Reset
REQ-034 rst_n low SHALL immediately, without waiting for a clock edge, force state IDLE, busy=0, done=0, overflow=0, result=0, and n, a, b = 0.
REQ-035 Reset asserted mid-computation SHALL discard the computation with no done pulse.
REQ-036 After rst_n rises, the block SHALL remain in IDLE until start.

Verification
REQ-037 W=32 with n=10, a=0, b=1 and mode=0: done SHALL rise at E0+11 with result=55, overflow=0, and busy high for 11 cycles.
REQ-038 n=0 with a=7 and b=9: done SHALL rise at E0+1 with result=7.
REQ-039 W=8 with n=14, a=0 and b=1: mode=0 SHALL give result=121, overflow=1; mode=1 SHALL give result=255, overflow=1.
REQ-040 n=20 run with abort at E0+5: busy SHALL fall at E0+6, done SHALL stay 0, and result SHALL keep its prior value; a new start then SHALL complete normally.
REQ-041 rst_n pulsed low mid-RUN between clock edges: all outputs SHALL go to 0 asynchronously, and no done SHALL follow.
REQ-042 start held high in DONE: a new computation SHALL begin at that edge, and done SHALL go low for exactly n+1 cycles.
